// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared defaults, CeilLog helper and write-request record
package regfile_write_arbiter_pkg;

    localparam int DEFAULT_WORD_LENGTH   = 32;
    localparam int DEFAULT_NUM_REGISTERS = 32;
    localparam int DEFAULT_ADDR_LENGTH   = 5;

    function automatic int CeilLog(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic [DEFAULT_ADDR_LENGTH-1:0] addr;
        logic [DEFAULT_WORD_LENGTH-1:0] data;
    } write_req_t;

endpackage

// File: rtl/reg_write_fifo.sv
// rtl/reg_write_fifo.sv - per-requester write FIFO with an entry-address view for hazard tracking
module reg_write_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_LENGTH,
    parameter int DATA_W = DEFAULT_WORD_LENGTH,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = CeilLog(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign entry_addr = addr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot k positions past the read pointer is live while k is below the count.
    always_comb begin
        entry_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                entry_valid[rd_ptr_q + PTR_W'(k)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the register-file write port between two requesters
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WORD_LENGTH   = DEFAULT_WORD_LENGTH,
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    parameter int ADDR_LENGTH   = DEFAULT_ADDR_LENGTH,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_LENGTH-1:0]   req0_addr,
    input  logic [WORD_LENGTH-1:0]   req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_LENGTH-1:0]   req1_addr,
    input  logic [WORD_LENGTH-1:0]   req1_data,
    output logic                     write,
    output logic [ADDR_LENGTH-1:0]   write_register,
    output logic [WORD_LENGTH-1:0]   write_data,
    output logic [NUM_REGISTERS-1:0] pending_mask,
    output logic                     grant_id
);

    typedef struct packed {
        logic [ADDR_LENGTH-1:0] addr;
        logic [WORD_LENGTH-1:0] data;
    } req_t;

    logic full0, empty0, full1, empty1;
    logic push0, push1, pop0, pop1;
    logic [ADDR_LENGTH-1:0] head0_addr, head1_addr;
    logic [WORD_LENGTH-1:0] head0_data, head1_data;
    logic [FIFO_DEPTH-1:0]                  entry_valid0, entry_valid1;
    logic [FIFO_DEPTH-1:0][ADDR_LENGTH-1:0] entry_addr0, entry_addr1;
    req_t head_sel;
    logic grant_valid, grant_sel;

    logic                   write_q, write_d;
    logic [ADDR_LENGTH-1:0] write_register_q, write_register_d;
    logic [WORD_LENGTH-1:0] write_data_q, write_data_d;
    logic                   grant_id_q, grant_id_d;
    logic                   favour_q, favour_d;

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    // Writes to register 0 are accepted but dropped: they have no architectural effect.
    assign push0 = req0_valid && !full0 && (req0_addr != '0);
    assign push1 = req1_valid && !full1 && (req1_addr != '0);

    reg_write_fifo #(
        .ADDR_W (ADDR_LENGTH),
        .DATA_W (WORD_LENGTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo0 (
        .clk         (clk),
        .reset       (reset),
        .push        (push0),
        .push_addr   (req0_addr),
        .push_data   (req0_data),
        .pop         (pop0),
        .full        (full0),
        .empty       (empty0),
        .head_addr   (head0_addr),
        .head_data   (head0_data),
        .entry_valid (entry_valid0),
        .entry_addr  (entry_addr0)
    );

    reg_write_fifo #(
        .ADDR_W (ADDR_LENGTH),
        .DATA_W (WORD_LENGTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo1 (
        .clk         (clk),
        .reset       (reset),
        .push        (push1),
        .push_addr   (req1_addr),
        .push_data   (req1_data),
        .pop         (pop1),
        .full        (full1),
        .empty       (empty1),
        .head_addr   (head1_addr),
        .head_data   (head1_data),
        .entry_valid (entry_valid1),
        .entry_addr  (entry_addr1)
    );

    // favour_q names the requester that wins when both FIFOs hold entries.
    always_comb begin
        grant_valid      = !empty0 || !empty1;
        grant_sel        = (!empty0 && !empty1) ? favour_q : !empty1;
        pop0             = grant_valid && !grant_sel;
        pop1             = grant_valid && grant_sel;
        head_sel         = grant_sel ? '{addr: head1_addr, data: head1_data}
                                     : '{addr: head0_addr, data: head0_data};
        write_d          = grant_valid;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        grant_id_d       = grant_id_q;
        favour_d         = favour_q;
        if (grant_valid) begin
            write_register_d = head_sel.addr;
            write_data_d     = head_sel.data;
            grant_id_d       = grant_sel;
            favour_d         = !grant_sel;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid0[i]) pending_mask[entry_addr0[i]] = 1'b1;
            if (entry_valid1[i]) pending_mask[entry_addr1[i]] = 1'b1;
        end
        if (write_q) pending_mask[write_register_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q          <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            grant_id_q       <= 1'b0;
            favour_q         <= 1'b0;
        end else begin
            write_q          <= write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            grant_id_q       <= grant_id_d;
            favour_q         <= favour_d;
        end
    end

    assign write          = write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign grant_id       = grant_id_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: requester 0 is pipeline writeback, requester 1 is the multicycle multiply/load unit.
- Each requester has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs into registered write/write_register/write_data outputs that drive the register file directly.
- Exports a pending-write mask for hazard detection.

Parameters:
- WORD_LENGTH, 32, data width of a write.
- NUM_REGISTERS, 32, number of architectural registers.
- ADDR_LENGTH, 5, register address width; equals ceil(log2(NUM_REGISTERS)).
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 offers a write.
- req0_ready  output  1  requester 0 FIFO not full.
- req0_addr  input  ADDR_LENGTH  requester 0 destination register.
- req0_data  input  WORD_LENGTH  requester 0 write data.
- req1_valid  input  1  requester 1 offers a write.
- req1_ready  output  1  requester 1 FIFO not full.
- req1_addr  input  ADDR_LENGTH  requester 1 destination register.
- req1_data  input  WORD_LENGTH  requester 1 write data.
- write  output  1  register-file write enable (registered).
- write_register  output  ADDR_LENGTH  register-file write address (registered).
- write_data  output  WORD_LENGTH  register-file write data (registered).
- pending_mask  output  NUM_REGISTERS  bit r set while any queued or in-flight write targets register r.
- grant_id  output  1  requester whose entry is currently on the write port (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs are emptied.
  - write, write_register, write_data and grant_id are 0.
  - The round-robin pointer favours requester 0.
  - pending_mask is 0; req0_ready and req1_ready are 1 once reset is released.
- Reset mid-operation discards all queued and in-flight writes; no partial write is issued.
- Handshake:
  - A transfer occurs on a rising edge with reqN_valid=1 and reqN_ready=1.
  - reqN_ready = !fullN, computed combinationally from the FIFO count only, with no pass-through: a full FIFO shows ready=0 even in a cycle when it pops.
- Register 0: a transfer with reqN_addr=0 completes the handshake but is not enqueued. It never reaches the write port and never sets pending_mask.
- Arbitration and drain, evaluated at each rising edge:
  - Neither FIFO non-empty: write<=0; write_register, write_data and grant_id hold.
  - Exactly one FIFO non-empty: pop its head into the output registers, write<=1, grant_id<=that requester.
  - Both non-empty: grant the requester not granted last, then pop, write<=1 and set grant_id as above.
  - The pointer updates only on a grant.
- Latency:
  - Entry accepted at edge k into an empty FIFO is popped at edge k+1.
  - write=1 during the cycle after k+1; the register file captures it at edge k+2.
  - Sustained throughput is one write per cycle total.
- Ordering:
  - Per-requester order is preserved.
  - Cross-requester order follows grant order only; same-address writes from both requesters land in grant order.
- Simultaneous push and pop on the same FIFO in one cycle is legal; the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is ADDR-independent, width ceil(log2(FIFO_DEPTH))+1.
- pending_mask is combinational: the OR of a one-hot decode of every valid FIFO entry address, plus write_register when write=1.
- A FIFO never overflows or underflows; pushes when full cannot occur by construction.

Decomposition:
- Shared package holds:
  - WORD_LENGTH, NUM_REGISTERS and ADDR_LENGTH defaults.
  - The CeilLog function.
  - A write-request record: addr plus data.
- One sub-module, reg_write_fifo:
  - Parameterised FIFO with push, pop, full, empty, head and an entry-address view for the pending mask.
  - Instantiated twice.
- The arbiter, output registers and mask logic stay in the top module.

Test Plan:
1. Reset, then req0 writes addr 5, data 0xDEADBEEF at edge 1 -> write=1, write_register=5, write_data=0xDEADBEEF, grant_id=0 during the cycle after edge 2. pending_mask bit 5 is set from edge 1 through the cycle after edge 2.
2. Both requesters push every cycle: req0 pushes addrs 1, 2, 3; req1 pushes addrs 9, 10, 11 -> the write port alternates 1, 9, 2, 10, 3, 11 with no idle cycles once started.
3. Hold req1_valid=1 while the write port is kept busy by requester 0 -> req1_ready drops to 0 after FIFO_DEPTH=2 accepts. No entry is lost; all accepted entries appear later, in order.
4. req0 writes addr 0, data 0x12345678 -> handshake completes, write stays 0, pending_mask stays 0.
5. Both requesters target addr 7 (req0 data 0xA, req1 data 0xB) in the same cycle, right after reset -> 0xA is written first (pointer favours 0), then 0xB. The final register value is 0xB.
6. Assert reset low with 3 entries queued and write=1 -> write=0 and pending_mask=0 immediately, without waiting for a clock edge. No writes appear after reset is released.
